// File: rtl/neuron_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_mac_pkg
//  Description : Shared widths and signed saturation limits for the neuron
//                multiply-accumulate stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_mac_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH;

    // Signed extremes of the data and accumulator formats
    localparam logic signed [DEF_DATA_WIDTH-1:0] DEF_DATA_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_DATA_WIDTH-1:0] DEF_DATA_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DEF_ACC_WIDTH-1:0]  DEF_ACC_MAX  = {1'b0, {(DEF_ACC_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_ACC_WIDTH-1:0]  DEF_ACC_MIN  = {1'b1, {(DEF_ACC_WIDTH-1){1'b0}}};

endpackage : neuron_mac_pkg
`default_nettype wire

// File: rtl/neuron_mac_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : sat_add
//  Description : Parameterised signed two's-complement adder that clamps to
//                the signed max/min of WIDTH on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_add
    import neuron_mac_pkg::*;
#(
    parameter int WIDTH = DEF_ACC_WIDTH
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] sum_o
);

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] w_raw;
    logic                    w_ovf;

    // Overflow only when both operands share a sign and the wrapped sum flips it
    assign w_raw = a_i + b_i;
    assign w_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_raw[WIDTH-1] != a_i[WIDTH-1]);
    assign sum_o = w_ovf ? (a_i[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_raw;

endmodule : sat_add
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_mac
//  Description : Three-stage per-neuron MAC. Stage 0 multiplies the streamed
//                input by the weight read at w_radd, stage 1 accumulates with
//                saturation, stage 2 adds the bias, rescales and saturates to
//                DATA_WIDTH. Define NEURON_RELU_EN to clamp negative results
//                to zero at the output.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int NUM_WEIGHT = 784,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [ADDR_WIDTH-1:0] w_radd,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  bias_wen,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int ACC_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHT - 1);
    // Output range expressed at accumulator width for the final clamp
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Stage 0 state
    logic [ADDR_WIDTH-1:0]        cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]  prod_q, prod_d;
    logic                         mul_valid_q;
    logic                         mul_last_q;
    // Stage 1 state
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  sum_q;
    logic                         sum_valid_q;
    // Stage 2 state
    logic [DATA_WIDTH-1:0]        bias_q;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
    logic                         out_valid_q;

    logic signed [ACC_WIDTH-1:0]  w_in_ext, w_wt_ext;
    logic signed [ACC_WIDTH-1:0]  w_acc_sum;
    logic signed [ACC_WIDTH-1:0]  w_bias_ext, w_bias_sh;
    logic signed [ACC_WIDTH-1:0]  w_biased;
    logic signed [ACC_WIDTH-1:0]  w_shr;

    // Sign-extend operands so the product is formed at full accumulator width
    assign w_in_ext = {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
    assign w_wt_ext = {{(ACC_WIDTH-DATA_WIDTH){w_data[DATA_WIDTH-1]}}, w_data};

    // Stage 0 next-state: product and wrapping weight address
    always_comb begin
        prod_d = w_in_ext * w_wt_ext;
        cnt_d  = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    end

    sat_add #(.WIDTH(ACC_WIDTH)) u_sat_acc (
        .a_i   (acc_q),
        .b_i   (prod_q),
        .sum_o (w_acc_sum)
    );

    // Bias is aligned to the product's binary point (2*FRAC_BITS) before adding
    assign w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
    assign w_bias_sh  = w_bias_ext <<< FRAC_BITS;

    sat_add #(.WIDTH(ACC_WIDTH)) u_sat_bias (
        .a_i   (sum_q),
        .b_i   (w_bias_sh),
        .sum_o (w_biased)
    );

    // Stage 2 rescale back to FRAC_BITS, clamp to DATA_WIDTH, optional ReLU
    always_comb begin
        w_shr = w_biased >>> FRAC_BITS;
        if (w_shr > OUT_MAX) begin
            out_data_d = OUT_MAX[DATA_WIDTH-1:0];
        end else if (w_shr < OUT_MIN) begin
            out_data_d = OUT_MIN[DATA_WIDTH-1:0];
        end else begin
            out_data_d = w_shr[DATA_WIDTH-1:0];
        end
`ifdef NEURON_RELU_EN
        if (out_data_d[DATA_WIDTH-1]) begin
            out_data_d = '0;
        end
`else
`endif
    end

    // Stage 0: capture product and advance the address on each valid input
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            prod_q      <= '0;
            mul_valid_q <= 1'b0;
            mul_last_q  <= 1'b0;
        end else begin
            mul_valid_q <= in_valid;
            if (in_valid) begin
                prod_q     <= prod_d;
                mul_last_q <= (cnt_q == LAST_IDX);
                cnt_q      <= cnt_d;
            end
        end
    end

    // Stage 1: accumulate; on the last term hand off the sum and clear for the next vector
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_valid_q <= mul_valid_q && mul_last_q;
            if (mul_valid_q) begin
                if (mul_last_q) begin
                    sum_q <= w_acc_sum;
                    acc_q <= '0;
                end else begin
                    acc_q <= w_acc_sum;
                end
            end
        end
    end

    // Stage 2: bias register load and registered activation output
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (bias_wen) begin
                bias_q <= bias_in;
            end
            out_valid_q <= sum_valid_q;
            if (sum_valid_q) begin
                out_data_q <= out_data_d;
            end
        end
    end

    assign w_radd    = cnt_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (cnt_q != '0) | mul_valid_q | sum_valid_q;

endmodule : neuron_mac
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_mac
//  Description : Self-checking bench for neuron_mac with a 4-entry weight
//                memory and a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_neuron_mac;

    localparam int NW = 4;
    localparam int AW = 2;
    localparam int DW = 16;
    localparam int FB = 8;

    typedef logic [DW-1:0] vec_t [NW];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] w_radd;
    logic [DW-1:0] w_data;
    logic          bias_wen = 1'b0;
    logic [DW-1:0] bias_in = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;

    neuron_mac #(
        .NUM_WEIGHT (NW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .w_radd    (w_radd),
        .w_data    (w_data),
        .bias_wen  (bias_wen),
        .bias_in   (bias_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] wmem [NW];
    assign w_data = wmem[w_radd];

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] bias_model = '0;
    logic [DW-1:0] obs_data [$];
    int            obs_cyc  [$];
    int            radd_seen[$];
    int            radd_pos [$];

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_data.push_back(out_data);
            obs_cyc.push_back(cyc);
        end
    end

    // Reference: dot product with clamp after every add, bias at Q(2*FB), rescale, clamp
    function automatic logic [DW-1:0] ref_out(input vec_t x, input vec_t w, input logic [DW-1:0] b);
        longint acc;
        longint t;
        longint s;
        logic [63:0] r;
        acc = 0;
        for (int i = 0; i < NW; i++) begin
            acc = acc + longint'($signed(x[i])) * longint'($signed(w[i]));
            if (acc > 64'sd2147483647) acc = 64'sd2147483647;
            if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        end
        t = acc + longint'($signed(b)) * 256;
        if (t > 64'sd2147483647) t = 64'sd2147483647;
        if (t < -64'sd2147483648) t = -64'sd2147483648;
        s = t >>> FB;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef NEURON_RELU_EN
        if (s < 0) s = 0;
`endif
        r = s;
        return r[DW-1:0];
    endfunction

    task automatic clear_logs();
        obs_data.delete();
        obs_cyc.delete();
        radd_seen.delete();
        radd_pos.delete();
    endtask

    task automatic fill_w(input logic [DW-1:0] v);
        for (int i = 0; i < NW; i++) wmem[i] = v;
    endtask

    task automatic load_bias(input logic [DW-1:0] b);
        @(negedge clk);
        bias_wen = 1'b1;
        bias_in  = b;
        @(negedge clk);
        bias_wen = 1'b0;
        bias_model = b;
    endtask

    // Drive one vector, with 'gaps' idle cycles spread randomly between samples
    task automatic send_vec(input vec_t x, input int gaps, input bit keep,
                            input bit bias_last, input logic [DW-1:0] nb, output int last_cyc);
        int g [NW];
        for (int i = 0; i < NW; i++) g[i] = 0;
        for (int k = 0; k < gaps; k++) g[$urandom_range(NW-1, 1)]++;
        last_cyc = 0;
        for (int i = 0; i < NW; i++) begin
            for (int j = 0; j < g[i]; j++) begin
                @(negedge clk);
                in_valid = 1'b0;
                bias_wen = 1'b0;
                radd_seen.push_back(int'(w_radd));
                radd_pos.push_back(i);
            end
            @(negedge clk);
            radd_seen.push_back(int'(w_radd));
            radd_pos.push_back(i);
            in_valid = 1'b1;
            in_data  = x[i];
            bias_wen = bias_last && (i == NW-1);
            bias_in  = nb;
            last_cyc = cyc;
        end
        if (!keep) begin
            @(negedge clk);
            in_valid = 1'b0;
            bias_wen = 1'b0;
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (obs_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (w_radd !== '0)     begin n_errors++; $display("FAIL reset_w_radd: got %h expected 0", w_radd); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== '0)   begin n_errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        vec_t x;
        logic [DW-1:0] exp_v;
        int lc;
        x = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        fill_w(16'h0100);
        load_bias(16'h0080);
        clear_logs();
        send_vec(x, 0, 1'b0, 1'b0, '0, lc);
        n_checks++; if (w_radd !== '0)  begin n_errors++; $display("FAIL basic_w_radd_wrap: got %h expected 0", w_radd); end
        n_checks++; if (busy !== 1'b1)  begin n_errors++; $display("FAIL basic_busy_pipe: got %b expected 1", busy); end
        foreach (radd_seen[i]) begin
            n_checks++;
            if (radd_seen[i] !== radd_pos[i]) begin n_errors++; $display("FAIL basic_w_radd_seq[%0d]: got %0d expected %0d", i, radd_seen[i], radd_pos[i]); end
        end
        exp_v = ref_out(x, wmem, bias_model);
        wait_out(1, 20);
        n_checks++;
        if (obs_data.size() !== 1) begin
            n_errors++; $display("FAIL basic_count: got %0d expected 1", obs_data.size());
        end else begin
            n_checks++; if (obs_data[0] !== exp_v) begin n_errors++; $display("FAIL basic_value: got %h expected %h", obs_data[0], exp_v); end
            n_checks++; if (obs_cyc[0] !== lc + 3) begin n_errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", obs_cyc[0], lc + 3); end
        end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_saturation();
        vec_t x;
        logic [DW-1:0] exp_v;
        int lc;
        fill_w(16'h7FFF);
        load_bias(16'h7FFF);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NW; i++) x[i] = (pass == 0) ? 16'h7FFF : 16'h8000;
            clear_logs();
            send_vec(x, 0, 1'b0, 1'b0, '0, lc);
            exp_v = ref_out(x, wmem, bias_model);
            wait_out(1, 20);
            n_checks++;
            if (obs_data.size() !== 1) begin
                n_errors++; $display("FAIL sat_count[%0d]: got %0d expected 1", pass, obs_data.size());
            end else begin
                n_checks++; if (obs_data[0] !== exp_v) begin n_errors++; $display("FAIL sat_value[%0d]: got %h expected %h", pass, obs_data[0], exp_v); end
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t x1, x2;
        logic [DW-1:0] e1, e2;
        int lc1, lc2;
        x1 = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        x2 = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        fill_w(16'h0100);
        load_bias(16'h0080);
        clear_logs();
        send_vec(x1, 0, 1'b1, 1'b0, '0, lc1);
        send_vec(x2, 0, 1'b0, 1'b0, '0, lc2);
        e1 = ref_out(x1, wmem, bias_model);
        e2 = ref_out(x2, wmem, bias_model);
        wait_out(2, 30);
        n_checks++;
        if (obs_data.size() !== 2) begin
            n_errors++; $display("FAIL b2b_count: got %0d expected 2", obs_data.size());
        end else begin
            n_checks++; if (obs_data[0] !== e1) begin n_errors++; $display("FAIL b2b_value0: got %h expected %h", obs_data[0], e1); end
            n_checks++; if (obs_data[1] !== e2) begin n_errors++; $display("FAIL b2b_value1: got %h expected %h", obs_data[1], e2); end
            n_checks++; if (obs_cyc[1] - obs_cyc[0] !== NW) begin n_errors++; $display("FAIL b2b_spacing: got %0d expected %0d", obs_cyc[1] - obs_cyc[0], NW); end
            n_checks++; if (obs_cyc[1] !== lc2 + 3) begin n_errors++; $display("FAIL b2b_latency: got cycle %0d expected %0d", obs_cyc[1], lc2 + 3); end
        end
    endtask

    task automatic test_gaps();
        vec_t x;
        logic [DW-1:0] exp_v;
        int lc;
        x = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        fill_w(16'h0100);
        clear_logs();
        send_vec(x, 3, 1'b0, 1'b0, '0, lc);
        n_checks++; if (radd_seen.size() !== NW + 3) begin n_errors++; $display("FAIL gaps_log_len: got %0d expected %0d", radd_seen.size(), NW + 3); end
        foreach (radd_seen[i]) begin
            n_checks++;
            if (radd_seen[i] !== radd_pos[i]) begin n_errors++; $display("FAIL gaps_w_radd_hold[%0d]: got %0d expected %0d", i, radd_seen[i], radd_pos[i]); end
        end
        exp_v = ref_out(x, wmem, bias_model);
        wait_out(1, 20);
        n_checks++;
        if (obs_data.size() !== 1) begin
            n_errors++; $display("FAIL gaps_count: got %0d expected 1", obs_data.size());
        end else begin
            n_checks++; if (obs_data[0] !== exp_v) begin n_errors++; $display("FAIL gaps_value: got %h expected %h", obs_data[0], exp_v); end
        end
    endtask

    task automatic test_reset_mid();
        vec_t x;
        logic [DW-1:0] exp_v;
        int lc;
        x = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        fill_w(16'h0100);
        load_bias(16'h0080);
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = x[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // Reset clears the bias register too, so the model follows suit
        bias_model = '0;
        n_checks++; if (busy !== 1'b0)  begin n_errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (w_radd !== '0)  begin n_errors++; $display("FAIL rstmid_w_radd: got %h expected 0", w_radd); end
        load_bias(16'h0080);
        send_vec(x, 0, 1'b0, 1'b0, '0, lc);
        exp_v = ref_out(x, wmem, bias_model);
        wait_out(1, 20);
        n_checks++;
        if (obs_data.size() !== 1) begin
            n_errors++; $display("FAIL rstmid_count: got %0d expected 1", obs_data.size());
        end else begin
            n_checks++; if (obs_data[0] !== exp_v) begin n_errors++; $display("FAIL rstmid_value: got %h expected %h", obs_data[0], exp_v); end
        end
    endtask

    task automatic test_bias_switch();
        vec_t x;
        logic [DW-1:0] exp_v;
        int lc;
        x = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        fill_w(16'h0100);
        load_bias(16'h0080);
        // New bias written alongside the last input reaches stage 2 in time
        clear_logs();
        send_vec(x, 0, 1'b0, 1'b1, 16'hFF00, lc);
        bias_model = 16'hFF00;
        exp_v = ref_out(x, wmem, bias_model);
        wait_out(1, 20);
        n_checks++;
        if (obs_data.size() !== 1) begin
            n_errors++; $display("FAIL bias_last_count: got %0d expected 1", obs_data.size());
        end else begin
            n_checks++; if (obs_data[0] !== exp_v) begin n_errors++; $display("FAIL bias_last_value: got %h expected %h", obs_data[0], exp_v); end
        end
        // Write coincident with the stage-2 edge: old bias applies to this result
        clear_logs();
        send_vec(x, 0, 1'b0, 1'b0, '0, lc);
        @(negedge clk);
        bias_wen = 1'b1;
        bias_in  = 16'h0080;
        @(negedge clk);
        bias_wen = 1'b0;
        exp_v = ref_out(x, wmem, bias_model);
        wait_out(1, 20);
        n_checks++;
        if (obs_data.size() !== 1) begin
            n_errors++; $display("FAIL bias_coinc_count: got %0d expected 1", obs_data.size());
        end else begin
            n_checks++; if (obs_data[0] !== exp_v) begin n_errors++; $display("FAIL bias_coinc_value: got %h expected %h", obs_data[0], exp_v); end
        end
        bias_model = 16'h0080;
        clear_logs();
        send_vec(x, 0, 1'b0, 1'b0, '0, lc);
        exp_v = ref_out(x, wmem, bias_model);
        wait_out(1, 20);
        n_checks++;
        if (obs_data.size() !== 1) begin
            n_errors++; $display("FAIL bias_after_count: got %0d expected 1", obs_data.size());
        end else begin
            n_checks++; if (obs_data[0] !== exp_v) begin n_errors++; $display("FAIL bias_after_value: got %h expected %h", obs_data[0], exp_v); end
        end
    endtask

    task automatic test_random();
        vec_t x;
        logic [DW-1:0] exp_v;
        int lc;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NW; i++) begin
                wmem[i] = DW'($urandom);
                x[i]    = DW'($urandom);
            end
            load_bias(DW'($urandom));
            clear_logs();
            send_vec(x, int'($urandom_range(3, 0)), 1'b0, 1'b0, '0, lc);
            exp_v = ref_out(x, wmem, bias_model);
            wait_out(1, 25);
            n_checks++;
            if (obs_data.size() !== 1) begin
                n_errors++; $display("FAIL rand_count[%0d]: got %0d expected 1", it, obs_data.size());
            end else begin
                n_checks++; if (obs_data[0] !== exp_v) begin n_errors++; $display("FAIL rand_value[%0d]: got %h expected %h", it, obs_data[0], exp_v); end
            end
        end
    endtask

    initial begin
        fill_w(16'h0100);
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_bias_switch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_neuron_mac
`default_nettype wire
